// File: rtl/mfp_srec_word_coalescing_ahb_writer_if.sv
// AHB-Lite write-master bundle for the SREC loader.
// Master drives address/control/data; slave returns HREADY.
interface mfp_srec_word_coalescing_ahb_writer_if;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HREADY;

  modport master (
    output HADDR,
    output HBURST,
    output HMASTLOCK,
    output HPROT,
    output HSIZE,
    output HTRANS,
    output HWDATA,
    output HWRITE,
    input  HREADY
  );

  modport slave (
    input  HADDR,
    input  HBURST,
    input  HMASTLOCK,
    input  HPROT,
    input  HSIZE,
    input  HTRANS,
    input  HWDATA,
    input  HWRITE,
    output HREADY
  );
endinterface

// File: rtl/mfp_srec_word_coalescing_ahb_writer.sv
// Coalesces parser bytes into word entries, queues them,
// and drains them as single AHB-Lite writes.
module mfp_srec_word_coalescing_ahb_writer #(
  parameter int unsigned FIFO_AW   = 2,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        big_endian,
  input  logic [31:0] write_address,
  input  logic [7:0]  write_byte,
  input  logic        write_enable,
  input  logic        flush,
  mfp_srec_word_coalescing_ahb_writer_if.master ahb,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  function automatic logic [1:0] first_lane(
    input logic [3:0] m
  );
    logic [1:0] k;
    if (m[0])      k = 2'd0;
    else if (m[1]) k = 2'd1;
    else if (m[2]) k = 2'd2;
    else           k = 2'd3;
    return k;
  endfunction

  logic [29:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [3:0]  buf_mask_q, buf_mask_d;

  entry_t             mem_q [DEPTH];
  logic [FIFO_AW:0]   wptr_q, rptr_q;
  logic               overflow_q;

  state_t      state_q;
  logic [31:0] haddr_q;
  logic [2:0]  hsize_q;
  logic [1:0]  htrans_q;
  logic [31:0] hwdata_q;
  logic        hwrite_q;
  logic [29:0] cur_addr_q;
  logic [31:0] cur_data_q;
  logic [3:0]  rem_mask_q;

  logic [1:0]  lane;
  logic [1:0]  dlane;
  logic [31:0] byte_word;
  logic [31:0] lane_bits;
  logic [3:0]  byte_mask;
  logic        addr_hit;
  logic        push;
  entry_t      push_e;
  logic        empty;
  logic        full;
  logic        pop;
  logic        fifo_we;
  entry_t      head;
  logic [1:0]  head_k;
  logic [1:0]  rem_k;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign head  = mem_q[rptr_q[FIFO_AW-1:0]];
  assign pop   = (state_q == S_IDLE) && !empty;
  assign fifo_we = push && (!full || pop);
  assign head_k = first_lane(head.mask);
  assign rem_k  = first_lane(rem_mask_q);

  always_comb begin
    lane      = write_address[1:0];
    dlane     = big_endian ? ~lane : lane;
    byte_word = {24'h0, write_byte} << {dlane, 3'b000};
    lane_bits = 32'h0000_00ff << {dlane, 3'b000};
    byte_mask = 4'b0001 << lane;
    addr_hit  = (write_address[31:2] == buf_addr_q);
    push       = 1'b0;
    push_e     = '0;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_mask_d = buf_mask_q;
    if (write_enable && (buf_mask_q != 4'h0) && !addr_hit) begin
      // New word: retire the old one, keep only this byte.
      push       = 1'b1;
      push_e     = '{buf_addr_q, buf_data_q, buf_mask_q};
      buf_addr_d = write_address[31:2];
      buf_data_d = byte_word;
      buf_mask_d = byte_mask;
    end else begin
      if (write_enable) begin
        buf_addr_d = write_address[31:2];
        buf_data_d = (buf_data_q & ~lane_bits) | byte_word;
        buf_mask_d = buf_mask_q | byte_mask;
      end
      if ((buf_mask_d == 4'hf) ||
          (flush && (buf_mask_d != 4'h0))) begin
        push       = 1'b1;
        push_e     = '{buf_addr_d, buf_data_d, buf_mask_d};
        buf_data_d = 32'h0;
        buf_mask_d = 4'h0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      buf_addr_q <= 30'h0;
      buf_data_q <= 32'h0;
      buf_mask_q <= 4'h0;
    end else begin
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      buf_mask_q <= buf_mask_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (fifo_we) begin
      mem_q[wptr_q[FIFO_AW-1:0]] <= push_e;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fifo_we) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      haddr_q    <= 32'h0;
      hsize_q    <= 3'b000;
      htrans_q   <= 2'b00;
      hwdata_q   <= 32'h0;
      hwrite_q   <= 1'b0;
      cur_addr_q <= 30'h0;
      cur_data_q <= 32'h0;
      rem_mask_q <= 4'h0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!empty) begin
            cur_addr_q <= head.addr;
            cur_data_q <= head.data;
            htrans_q   <= 2'b10;
            hwrite_q   <= 1'b1;
            state_q    <= S_ADDR;
            if (head.mask == 4'hf) begin
              haddr_q    <= {head.addr, 2'b00};
              hsize_q    <= 3'b010;
              rem_mask_q <= 4'h0;
            end else begin
              haddr_q    <= {head.addr, head_k};
              hsize_q    <= 3'b000;
              rem_mask_q <= head.mask & (head.mask - 4'd1);
            end
          end
        end
        S_ADDR: begin
          if (ahb.HREADY) begin
            htrans_q <= 2'b00;
            hwrite_q <= 1'b0;
            hwdata_q <= cur_data_q;
            state_q  <= S_DATA;
          end
        end
        S_DATA: begin
          if (ahb.HREADY) begin
            if (rem_mask_q != 4'h0) begin
              haddr_q    <= {cur_addr_q, rem_k};
              hsize_q    <= 3'b000;
              htrans_q   <= 2'b10;
              hwrite_q   <= 1'b1;
              rem_mask_q <= rem_mask_q & (rem_mask_q - 4'd1);
              state_q    <= S_ADDR;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ahb.HADDR     = haddr_q;
  assign ahb.HBURST    = 3'b000;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HPROT     = HPROT_VAL;
  assign ahb.HSIZE     = hsize_q;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HWDATA    = hwdata_q;
  assign ahb.HWRITE    = hwrite_q;

  assign busy = (buf_mask_q != 4'h0) || !empty ||
                (state_q != S_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mfp_srec_word_coalescing_ahb_writer.sv
// Directed bench for the coalescing AHB writer.
// Transfers are captured by a bus monitor and checked in order.
module tb_mfp_srec_word_coalescing_ahb_writer;

  logic        HCLK;
  logic        HRESETn;
  logic        big_endian;
  logic [31:0] write_address;
  logic [7:0]  write_byte;
  logic        write_enable;
  logic        flush;
  logic        busy;
  logic        overflow;

  mfp_srec_word_coalescing_ahb_writer_if ahb ();

  mfp_srec_word_coalescing_ahb_writer #(
    .FIFO_AW   (2),
    .HPROT_VAL (4'b0011)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .big_endian    (big_endian),
    .write_address (write_address),
    .write_byte    (write_byte),
    .write_enable  (write_enable),
    .flush         (flush),
    .ahb           (ahb),
    .busy          (busy),
    .overflow      (overflow)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] qa [$];
  logic [2:0]  qs [$];
  logic [31:0] qd [$];
  logic        pend;
  logic [31:0] pa;
  logic [2:0]  ps;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Values seen at negedge are what the next rising edge samples.
  always @(negedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend = 1'b0;
    end else begin
      if (pend && ahb.HREADY) begin
        qa.push_back(pa);
        qs.push_back(ps);
        qd.push_back(ahb.HWDATA);
        pend = 1'b0;
      end
      if (ahb.HTRANS == 2'b10 && ahb.HWRITE && ahb.HREADY) begin
        pend = 1'b1;
        pa   = ahb.HADDR;
        ps   = ahb.HSIZE;
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [7:0] b);
    write_address = a;
    write_byte    = b;
    write_enable  = 1'b1;
    tick();
    write_enable  = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic clr_q();
    qa.delete();
    qs.delete();
    qd.delete();
  endtask

  task automatic chk_xfer(input string tag,
                          input int idx,
                          input logic [31:0] a,
                          input logic [2:0] s,
                          input logic [31:0] d);
    if (qa.size() > idx) begin
      chk({tag, "_addr"}, qa[idx], a);
      chk({tag, "_size"}, {29'h0, qs[idx]}, {29'h0, s});
      chk({tag, "_data"}, qd[idx], d);
    end else begin
      chk({tag, "_present"}, qa.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn       = 1'b0;
    big_endian    = 1'b0;
    write_address = 32'h0;
    write_byte    = 8'h0;
    write_enable  = 1'b0;
    flush         = 1'b0;
    ahb.HREADY    = 1'b1;
    tick();
    tick();
    chk("rst_htrans", {30'h0, ahb.HTRANS}, 32'h0);
    chk("rst_haddr", ahb.HADDR, 32'h0);
    chk("rst_hsize", {29'h0, ahb.HSIZE}, 32'h0);
    chk("rst_hwdata", ahb.HWDATA, 32'h0);
    chk("rst_hwrite", {31'h0, ahb.HWRITE}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    chk("hburst", {29'h0, ahb.HBURST}, 32'h0);
    chk("hprot", {28'h0, ahb.HPROT}, 32'h3);
    chk("hmastlock", {31'h0, ahb.HMASTLOCK}, 32'h0);
    HRESETn = 1'b1;
    tick();

    // Little-endian full word
    clr_q();
    wr(32'h100, 8'h11);
    wr(32'h101, 8'h22);
    wr(32'h102, 8'h33);
    wr(32'h103, 8'h44);
    wait_idle("le_idle");
    chk("le_count", qa.size(), 1);
    chk_xfer("le", 0, 32'h100, 3'b010, 32'h44332211);

    // Big-endian full word
    clr_q();
    big_endian = 1'b1;
    wr(32'h100, 8'h11);
    wr(32'h101, 8'h22);
    wr(32'h102, 8'h33);
    wr(32'h103, 8'h44);
    wait_idle("be_idle");
    big_endian = 1'b0;
    chk("be_count", qa.size(), 1);
    chk_xfer("be", 0, 32'h100, 3'b010, 32'h11223344);

    // Partial word flushed as a byte write
    clr_q();
    wr(32'h205, 8'hab);
    chk("part_busy", {31'h0, busy}, 32'h1);
    pulse_flush();
    wait_idle("part_idle");
    chk("part_count", qa.size(), 1);
    chk_xfer("part", 0, 32'h205, 3'b000, 32'h0000ab00);
    clr_q();
    pulse_flush();
    for (int i = 0; i < 5; i++) tick();
    chk("reflush_count", qa.size(), 0);
    chk("reflush_busy", {31'h0, busy}, 32'h0);

    // Address change retires the first word
    clr_q();
    wr(32'h300, 8'h01);
    wr(32'h310, 8'h02);
    pulse_flush();
    wait_idle("split_idle");
    chk("split_count", qa.size(), 2);
    chk_xfer("split0", 0, 32'h300, 3'b000, 32'h00000001);
    chk_xfer("split1", 1, 32'h310, 3'b000, 32'h00000002);

    // Wait states in both phases
    clr_q();
    ahb.HREADY = 1'b0;
    wr(32'h400, 8'ha0);
    wr(32'h401, 8'ha1);
    wr(32'h402, 8'ha2);
    wr(32'h403, 8'ha3);
    for (int i = 0; i < 20 && ahb.HTRANS != 2'b10; i++) tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_a_trans", {30'h0, ahb.HTRANS}, 32'h2);
      chk("stall_a_addr", ahb.HADDR, 32'h400);
      tick();
    end
    chk("stall_a_hold", {30'h0, ahb.HTRANS}, 32'h2);
    chk("stall_a_write", {31'h0, ahb.HWRITE}, 32'h1);
    ahb.HREADY = 1'b1;
    tick();
    ahb.HREADY = 1'b0;
    chk("stall_d_trans", {30'h0, ahb.HTRANS}, 32'h0);
    chk("stall_d_data", ahb.HWDATA, 32'ha3a2a1a0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_d_hold", ahb.HWDATA, 32'ha3a2a1a0);
      chk("stall_d_nodone", qa.size(), 0);
    end
    ahb.HREADY = 1'b1;
    tick();
    chk("stall_done", qa.size(), 1);
    chk_xfer("stall", 0, 32'h400, 3'b010, 32'ha3a2a1a0);
    wait_idle("stall_idle");

    // FIFO overflow with a dead slave, then reset mid-ADDR
    clr_q();
    ahb.HREADY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < 4; b++) begin
        wr(32'h1000 + 32'(i * 16 + b), 8'(i + 1));
      end
      chk($sformatf("ovf_%0d", i), {31'h0, overflow},
          (i >= 5) ? 32'h1 : 32'h0);
    end
    chk("ovf_busy", {31'h0, busy}, 32'h1);
    chk("ovf_in_addr", {30'h0, ahb.HTRANS}, 32'h2);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_trans", {30'h0, ahb.HTRANS}, 32'h0);
    chk("mid_rst_ovf", {31'h0, overflow}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_write", {31'h0, ahb.HWRITE}, 32'h0);
    tick();
    HRESETn    = 1'b1;
    ahb.HREADY = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_count", qa.size(), 0);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mfp_srec_word_coalescing_ahb_writer.md
Name: mfp_srec_word_coalescing_ahb_writer

Overview:
- Sits between mfp_srec_parser and the loader-side AHB-Lite master mux in front of mfp_ahb_lite_matrix.
- Merges the parser's byte-wide write stream into word-aligned entries and queues them in a small FIFO.
- Issues HREADY-aware single AHB-Lite write transfers: word writes when all 4 bytes are present, byte writes otherwise.
- Lets slow slaves (SDRAM) insert wait states without losing loader bytes.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth; depth = 2**FIFO_AW entries of {addr[31:2], data[31:0], mask[3:0]}.
- HPROT_VAL, 4'b0011, constant HPROT value driven on every transfer.

Ports:
- HCLK  in  1  system clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- big_endian  in  1  byte-lane ordering (SI_Endian); sampled per byte at merge time.
- write_address  in  32  byte address from parser.
- write_byte  in  8  byte data from parser.
- write_enable  in  1  one-cycle byte strobe.
- flush  in  1  one-cycle pulse: push partial word now (driven at end of load).
- HADDR  out  32  AHB address.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  constant HPROT_VAL.
- HSIZE  out  3  3'b010 word or 3'b000 byte.
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ.
- HWDATA  out  32  write data, valid in data phase.
- HWRITE  out  1  1 during address phase, else 0.
- HREADY  in  1  slave ready from matrix.
- busy  out  1  coalescing buffer, FIFO or FSM not empty/idle.
- overflow  out  1  sticky: an entry was dropped because FIFO was full.

Behaviour:
- Reset (async, HRESETn=0): HADDR=0, HSIZE=0, HTRANS=IDLE, HWDATA=0, HWRITE=0, busy=0, overflow=0; FIFO empty, buffer mask=0, FSM=IDLE.
- Byte lane k = addr[1:0]. Little endian: lane bits [8k+7:8k]. Big endian: [8(3-k)+7:8(3-k)].
- Coalescing buffer holds buf_addr[31:2], buf_data, buf_mask.
- On write_enable with buf_mask!=0 and write_address[31:2]!=buf_addr: push old entry; start new buffer with this byte only.
- Otherwise: merge byte into its lane, set mask bit. Rewriting the same lane overwrites data.
- When buf_mask becomes 4'b1111 in a cycle: push that same cycle, clear mask.
- flush: if mask!=0 after any same-cycle merge, push; if mask==0, no action.
- Push when FIFO full: entry dropped, overflow<=1 (sticky until reset); buffer still cleared/reloaded as above.
- At most one push per cycle. If a write_enable address change coincides with flush, push the old entry, then keep the new byte in the buffer (flushed on next flush pulse).
- Master FSM: IDLE, ADDR, DATA. No address/data overlap; every transfer takes 2 cycles minimum.
  - IDLE: if FIFO non-empty, pop entry and select first lane.
    - mask==1111: one word write, HADDR={addr,2'b00}, HSIZE=010.
    - otherwise: one byte write per set mask bit, in ascending address order, HADDR={addr,k}, HSIZE=000, HWDATA = full entry data word (unused lanes = 0).
  - ADDR: HTRANS=NONSEQ, HWRITE=1. Hold until HREADY=1, then go to DATA.
  - DATA: HTRANS=IDLE, HWRITE=0, HWDATA held stable until HREADY=1. Then go to the next byte of the same entry (ADDR), else IDLE.
  - Returning to IDLE with the FIFO non-empty: next ADDR issues the following cycle.
- HRESP is ignored; errors are not reported.
- FIFO push and pop in the same cycle while full: push accepted, no overflow.
- busy = (buf_mask!=0) | FIFO non-empty | FSM!=IDLE.
- Reset mid-transfer: all state is lost, outputs return to reset values immediately, and no completion is signalled.

Test Plan:
- LE (big_endian=0), bytes 11,22,33,44 to 0x100..0x103 -> one transfer: HADDR=0x100, HSIZE=010, HWDATA=0x44332211; then busy=0.
- Same sequence with big_endian=1 -> HWDATA=0x11223344.
- LE byte 0xAB at 0x205, then flush -> HADDR=0x205, HSIZE=000, HWDATA=0x0000AB00; no transfer on a second flush.
- Bytes at 0x300 (0x01) then 0x310 (0x02), then flush -> byte writes to 0x300 then 0x310, HWDATA 0x00000001 and 0x00000002.
- HREADY held low 3 cycles in ADDR and 2 cycles in DATA -> HADDR/HTRANS stable during the ADDR stall and HWDATA stable during the DATA stall; a transfer completes only after HREADY=1 in both phases.
- HREADY=0 forever, push 2**FIFO_AW+2 full words -> overflow=1 after entry index 2**FIFO_AW+1 (first entry sits in FSM); HRESETn pulse mid-ADDR -> HTRANS=00, overflow=0, busy=0.
